// File: rtl/mul_add_seq_if.sv
// Handshake and operand/result bundle for the shift-and-add multiply-accumulate unit.
// The master issues start with Q/D/R, and the slave returns N/P/ovf together with busy/done.
interface mul_add_seq_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   Q;
  logic [WIDTH-1:0]   D;
  logic [WIDTH-1:0]   R;
  logic [WIDTH-1:0]   N;
  logic [2*WIDTH-1:0] P;
  logic               ovf;
  logic               busy;
  logic               done;

  // Requester side: drives the operands and samples the results.
  modport master (
    output start, Q, D, R,
    input  N, P, ovf, busy, done
  );

  // Multiply-accumulate unit side.
  modport slave (
    input  start, Q, D, R,
    output N, P, ovf, busy, done
  );
endinterface

// File: rtl/mul_add_seq.sv
// Sequential shift-and-add multiply-accumulate: P = Q*D + R, with one multiplier bit per clock.
// This is the inverse of the restoring divider. Feeding it (quotient, divisor, remainder)
// rebuilds the numerator on N. Latency is fixed at WIDTH clocks from accepted start to done,
// and there is no early exit for small or zero multipliers.
module mul_add_seq #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  mul_add_seq_if.slave bus
);

  // The counter must hold values up to WIDTH-1. Sizing it for WIDTH+1 keeps WIDTH=1 legal.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] md_reg;
  logic [WIDTH-1:0]   mq_reg;
  logic [CW-1:0]      cnt_reg;

  logic [WIDTH-1:0]   n_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic               ovf_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [2*WIDTH-1:0] acc_next;
  logic               last_iter;

  // Partial-product step: add the shifted multiplicand when the current multiplier bit is set.
  // The sum cannot exceed (2^W-1)^2 + (2^W-1) < 2^(2W), so 2W bits never wrap.
  assign acc_next  = mq_reg[0] ? (acc_reg + md_reg) : acc_reg;
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  // Control FSM and datapath. Every output is registered, so N/P/ovf only move on the done edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      md_reg    <= '0;
      mq_reg    <= '0;
      cnt_reg   <= '0;
      n_reg     <= '0;
      p_reg     <= '0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          // start is only honoured here. While RUN it is ignored, not queued.
          if (bus.start) begin
            mq_reg    <= bus.Q;
            md_reg    <= {{WIDTH{1'b0}}, bus.D};
            acc_reg   <= {{WIDTH{1'b0}}, bus.R};
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          md_reg  <= md_reg << 1;
          mq_reg  <= mq_reg >> 1;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_iter) begin
            // Publish from acc_next so the final iteration lands on this edge, not the next one.
            p_reg     <= acc_next;
            n_reg     <= acc_next[WIDTH-1:0];
            ovf_reg   <= |acc_next[2*WIDTH-1:WIDTH];
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.N    = n_reg;
  assign bus.P    = p_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq: directed vector table, handshake corner sequences,
// a random sweep against an arithmetic model, and a divider round-trip sweep.
module tb_mul_add_seq;

  localparam int W = 16;

  logic clk;
  logic rst_n;

  mul_add_seq_if #(.WIDTH(W)) bus ();

  mul_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0]   q;
    logic [W-1:0]   d;
    logic [W-1:0]   r;
    logic [2*W-1:0] p;
    logic           ovf;
  } vec_t;

  vec_t vecs [6];

  // One comparison. A mismatch produces a FAIL line.
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one operation and waits for done, with a bounded wait.
  // sync=1 aligns to a negedge first. sync=0 drives start right away, which is used for
  // a start in the done cycle. If inj >= 0, start is pulsed and the operands are changed
  // at that cycle of the run.
  task automatic do_op(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                       input bit sync, input int inj, output int lat, output bit busy_ok);
    if (sync) @(negedge clk);
    bus.start = 1'b1;
    bus.Q = q;
    bus.D = d;
    bus.R = r;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (lat == inj) begin
        bus.start = 1'b1;
        bus.Q = ~q;
        bus.D = d ^ 16'h5A5A;
        bus.R = r + 16'd77;
      end else if (lat == inj + 1) begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
  endtask

  // Checks the full result of one operation against the arithmetic model.
  task automatic run_and_check(input string tag, input logic [W-1:0] q, input logic [W-1:0] d,
                               input logic [W-1:0] r, input bit sync, input int inj);
    int lat;
    bit bok;
    logic [2*W-1:0] exp_p;
    exp_p = (2*W)'(q) * (2*W)'(d) + (2*W)'(r);
    do_op(q, d, r, sync, inj, lat, bok);
    chk({tag, ".latency"}, 64'(lat), 64'd16);
    chk({tag, ".busy"}, 64'(bok), 64'd1);
    chk({tag, ".P"}, 64'(bus.P), 64'(exp_p));
    chk({tag, ".N"}, 64'(bus.N), 64'(exp_p[W-1:0]));
    chk({tag, ".ovf"}, 64'(bus.ovf), 64'(exp_p[2*W-1:W] != 0));
  endtask

  initial begin
    int lat;
    bit bok;
    bit saw_done;
    logic [W-1:0] q, d, r, nn;
    logic [2*W-1:0] p_hold;

    vecs[0] = '{q: 16'd7,    d: 16'd3,    r: 16'd2,    p: 32'd23,        ovf: 1'b0};
    vecs[1] = '{q: 16'd142,  d: 16'd7,    r: 16'd6,    p: 32'h000003E8,  ovf: 1'b0};
    vecs[2] = '{q: 16'hFFFF, d: 16'hFFFF, r: 16'hFFFF, p: 32'hFFFF0000,  ovf: 1'b1};
    vecs[3] = '{q: 16'h0100, d: 16'h0100, r: 16'h0000, p: 32'h00010000,  ovf: 1'b1};
    vecs[4] = '{q: 16'h0000, d: 16'h1234, r: 16'd5,    p: 32'd5,         ovf: 1'b0};
    vecs[5] = '{q: 16'hFFFF, d: 16'h0000, r: 16'h0000, p: 32'd0,         ovf: 1'b0};

    bus.start = 1'b0;
    bus.Q = '0;
    bus.D = '0;
    bus.R = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.P", 64'(bus.P), 64'd0);
    chk("reset.N", 64'(bus.N), 64'd0);
    chk("reset.ovf", 64'(bus.ovf), 64'd0);
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with constant expectations
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].q, vecs[i].d, vecs[i].r, 1'b1, -1, lat, bok);
      chk($sformatf("vec%0d.latency", i), 64'(lat), 64'd16);
      chk($sformatf("vec%0d.busy", i), 64'(bok), 64'd1);
      chk($sformatf("vec%0d.P", i), 64'(bus.P), 64'(vecs[i].p));
      chk($sformatf("vec%0d.N", i), 64'(bus.N), 64'(vecs[i].p[W-1:0]));
      chk($sformatf("vec%0d.ovf", i), 64'(bus.ovf), 64'(vecs[i].ovf));
      $display("vec%0d Q=%0h D=%0h R=%0h -> P=%0h ovf=%0b lat=%0d", i,
               vecs[i].q, vecs[i].d, vecs[i].r, bus.P, bus.ovf, lat);
      if (i == 0) begin
        @(posedge clk);
        #1;
        chk("done_pulse_width", 64'(bus.done), 64'd0);
      end
    end

    // Results hold while idle
    p_hold = bus.P;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_hold.P", 64'(bus.P), 64'(p_hold));

    // A start and operand change at cycle 5 are ignored
    run_and_check("ignore_start", 16'h1357, 16'h2468, 16'h0042, 1'b1, 5);
    $display("ignore_start P=%0h", bus.P);
    // Operands change mid-run, and the injected start is again ignored
    run_and_check("change_ops", 16'hBEEF, 16'h0F0F, 16'h1111, 1'b1, 11);
    $display("change_ops P=%0h", bus.P);

    // Back-to-back: start issued in the done cycle
    run_and_check("b2b_first", 16'd100, 16'd200, 16'd3, 1'b1, -1);
    run_and_check("b2b_second", 16'd321, 16'd999, 16'd17, 1'b0, -1);
    $display("b2b second P=%0h", bus.P);

    // Reset mid-operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.Q = 16'hABCD;
    bus.D = 16'h1234;
    bus.R = 16'h0007;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 64'(bus.busy), 64'd0);
    chk("midrst.P", 64'(bus.P), 64'd0);
    chk("midrst.N", 64'(bus.N), 64'd0);
    chk("midrst.ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    chk("midrst.no_done", 64'(saw_done), 64'd0);
    $display("mid-op reset, no done afterwards: %0b", !saw_done);
    run_and_check("after_rst", 16'd7, 16'd3, 16'd2, 1'b1, -1);

    // Random operands against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      q = W'($urandom);
      d = W'($urandom);
      r = W'($urandom);
      run_and_check($sformatf("rand%0d", i), q, d, r, 1'b1, -1);
      $display("rand%0d Q=%0h D=%0h R=%0h -> P=%0h", i, q, d, r, bus.P);
    end

    // Divider round trip: (N/D, D, N%D) must rebuild N
    for (int i = 0; i < 20; i++) begin
      nn = W'($urandom);
      d = W'($urandom_range(1, 65535));
      if (i < 4) d = W'(i + 1);
      q = nn / d;
      r = nn % d;
      do_op(q, d, r, 1'b1, -1, lat, bok);
      chk($sformatf("rt%0d.N", i), 64'(bus.N), 64'(nn));
      chk($sformatf("rt%0d.ovf", i), 64'(bus.ovf), 64'd0);
      $display("rt%0d N=%0h D=%0h -> rebuilt %0h", i, nn, d, bus.N);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
